uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver. It captures each accepted byte, signalled by a rising edge on the receiver's end-of-communication flag, and stores it in a DEPTH-entry circular FIFO. A first-word-fall-through read port lets the host drain bytes at its own pace. Overflow is reported by a sticky flag and a saturating drop counter.

Parameters:
DEPTH, 16, number of byte entries; must be a power of two and at least 2
ADDR_W, 4, pointer width; must equal log2(DEPTH)

Ports:
clk  input  1  system clock, same clock as the UART receiver
rst  input  1  asynchronous reset, active-low
buffer_RX  input  8  received byte from the UART receiver, stable while eoc_flag is high
eoc_flag  input  1  end-of-communication flag from the receiver; high only for a good frame (parity and stop bit OK)
rd_en  input  1  pop request from the consumer
clr_overflow  input  1  synchronous clear of the overflow flag and the drop counter
rd_data  output  8  head-of-FIFO byte, valid when rd_valid=1
rd_valid  output  1  FIFO not empty
full  output  1  count==DEPTH
empty  output  1  count==0
count  output  ADDR_W+1  number of stored bytes, 0..DEPTH
overflow  output  1  sticky: at least one byte was dropped because the FIFO was full
drop_cnt  output  8  number of dropped bytes, saturates at 255

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, overflow=0, drop_cnt=0, eoc_d=1.
- Memory contents are not reset. rd_data is don't-care while empty.
- Edge detect: eoc_d is the registered copy of eoc_flag. The write event is wr_ev = eoc_flag & ~eoc_d.
  - A multi-cycle-high eoc_flag produces exactly one write.
  - eoc_flag already high when reset is released produces no write, because eoc_d resets to 1.
- Write: on wr_ev with the FIFO not full, or with the FIFO full and a pop in the same cycle:
  - mem[wr_ptr] <= buffer_RX
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH
- Read (FWFT): rd_data = mem[rd_ptr] combinationally. Pop happens when rd_en & ~empty; then rd_ptr <= rd_ptr+1, wrapping.
  - rd_en while empty is ignored: no pointer change, no error.
- Count update per cycle:
  - write only: +1
  - pop only: -1
  - write and pop together: unchanged
  - neither: unchanged
- Flags: full, empty and rd_valid are registered, or derived from the registered count; both are legal.
  - A byte written in cycle N is visible on rd_data with rd_valid=1 in cycle N+1.
- Overflow: wr_ev while full with no simultaneous pop drops the byte.
  - No memory write, no pointer change.
  - overflow <= 1.
  - drop_cnt <= drop_cnt+1, saturating at 8'hFF.
- Simultaneous write and pop at full: both succeed; no overflow.
- Simultaneous write and rd_en at empty: the write succeeds, the pop is ignored, count becomes 1.
- clr_overflow: clears overflow and drop_cnt to 0 at the next edge.
  - If a drop occurs in the same cycle as clr_overflow: overflow=1 and drop_cnt=1 (set wins).
- Wrap-around: pointers are ADDR_W bits wide and wrap naturally. full/empty are derived from count, never from pointer comparison alone.
- Reset mid-operation: all state returns to reset values immediately; stored data is discarded.
- Latency: eoc_flag rising at edge N, wr_ev at edge N, byte readable at N+1.
- No combinational path from eoc_flag or buffer_RX to any output.

Test Plan:
- Single byte: after reset, pulse eoc_flag for 1 cycle with buffer_RX=8'hA5 -> next cycle rd_valid=1, rd_data=8'hA5, count=1; assert rd_en for 1 cycle -> empty=1, count=0.
- Held flag: eoc_flag high for 5 cycles with buffer_RX=8'h3C -> exactly one entry, count=1; eoc_flag held high through reset release -> count stays 0.
- Fill and wrap: write 16 bytes 8'h00..8'h0F -> full=1, count=16; pop 4 (read 00,01,02,03); write 8'h10..8'h13; drain all -> order 04..0F then 10..13, empty=1.
- Overflow: fill to 16, then 3 more writes without reads -> overflow=1, drop_cnt=3, contents still 00..0F; pulse clr_overflow -> overflow=0, drop_cnt=0. Write and pop in the same cycle at full -> no overflow, count=16.
- Saturation and priority: 300 writes into a full FIFO -> drop_cnt=255. A drop in the same cycle as clr_overflow -> overflow=1, drop_cnt=1. rd_en while empty -> no change.
- Reset mid-stream: 7 bytes stored, assert rst -> count=0, empty=1, overflow=0 asynchronously; after release, a new byte 8'h5A reads back first.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer placed directly after the UART receiver. Each good
// frame, marked by a rising edge on eoc_flag, is stored in a DEPTH-entry
// circular FIFO. The host drains it through a first-word-fall-through port.
// A byte that arrives while the FIFO is full is dropped. Each drop sets a
// sticky overflow flag and bumps a saturating drop counter.
//
// Ports
//   clk          system clock, shared with the UART receiver
//   rst          asynchronous reset, active-low
//   buffer_RX    received byte, stable while eoc_flag is high
//   eoc_flag     end-of-communication flag, high only for a good frame
//   rd_en        pop request from the consumer
//   clr_overflow synchronous clear of overflow and drop_cnt
//   rd_data      head-of-FIFO byte, valid when rd_valid is high
//   rd_valid     FIFO not empty
//   full         count == DEPTH
//   empty        count == 0
//   count        number of stored bytes, 0..DEPTH
//   overflow     sticky flag: at least one byte has been dropped
//   drop_cnt     number of dropped bytes, saturates at 255

module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        buffer_RX,
    input  logic              eoc_flag,
    input  logic              rd_en,
    input  logic              clr_overflow,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              eoc_q;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic wr_ev;
    logic pop;
    logic wr_ok;
    logic drop;

    // eoc_q resets high, so a flag that is already high when reset is
    // released does not count as a new frame.
    assign wr_ev = eoc_flag & ~eoc_q;
    assign pop   = rd_en & (count_q != '0);
    // A pop in the same cycle frees a slot, so a write at full still succeeds.
    assign wr_ok = wr_ev & ((count_q != CNT_FULL) | pop);
    assign drop  = wr_ev & (count_q == CNT_FULL) & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        if (wr_ok && !pop) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (!wr_ok && pop) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end

        // A drop in the same cycle as a clear wins: the counter restarts at 1.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_overflow) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            eoc_q      <= 1'b1;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            eoc_q      <= eoc_flag;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; its contents only matter once count says so.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= buffer_RX;
        end
    end

    assign rd_data  = mem[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign rd_valid = (count_q != '0);
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo. Inputs change and outputs are sampled
// 1 ns after each rising clock edge.

module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] buffer_RX;
    logic       eoc_flag;
    logic       rd_en;
    logic       clr_overflow;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .buffer_RX    (buffer_RX),
        .eoc_flag     (eoc_flag),
        .rd_en        (rd_en),
        .clr_overflow (clr_overflow),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle eoc_flag pulse followed by one low cycle so the next pulse
    // is seen as a fresh rising edge.
    task automatic wr(input logic [7:0] b);
        eoc_flag  = 1'b1;
        buffer_RX = b;
        tick();
        eoc_flag  = 1'b0;
        tick();
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, rd_data}, {24'd0, exp});
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        buffer_RX    = 8'h00;
        eoc_flag     = 1'b0;
        rd_en        = 1'b0;
        clr_overflow = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Reset state
        chk("rst_count",    {27'd0, count}, 32'd0);
        chk("rst_empty",    {31'd0, empty}, 32'd1);
        chk("rst_full",     {31'd0, full}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);

        // Single byte, visible on the cycle after the write edge
        eoc_flag  = 1'b1;
        buffer_RX = 8'hA5;
        tick();
        chk("single_valid", {31'd0, rd_valid}, 32'd1);
        chk("single_data",  {24'd0, rd_data}, 32'hA5);
        chk("single_count", {27'd0, count}, 32'd1);
        eoc_flag = 1'b0;
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("single_pop_empty", {31'd0, empty}, 32'd1);
        chk("single_pop_count", {27'd0, count}, 32'd0);

        // Held flag: one write only
        eoc_flag  = 1'b1;
        buffer_RX = 8'h3C;
        repeat (5) tick();
        chk("held_count", {27'd0, count}, 32'd1);
        chk("held_data",  {24'd0, rd_data}, 32'h3C);
        eoc_flag = 1'b0;
        tick();
        pop_chk("held_pop", 8'h3C);

        // Flag held high across reset release: no write
        rst      = 1'b0;
        eoc_flag = 1'b1;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("held_rst_count", {27'd0, count}, 32'd0);
        eoc_flag = 1'b0;
        tick();

        // rd_en while empty is ignored
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("rd_empty_count", {27'd0, count}, 32'd0);
        chk("rd_empty_empty", {31'd0, empty}, 32'd1);

        // Fill and wrap
        for (int i = 0; i < 16; i++) wr(8'(i));
        chk("fill_full",  {31'd0, full}, 32'd1);
        chk("fill_count", {27'd0, count}, 32'd16);
        for (int i = 0; i < 4; i++) pop_chk("wrap_pop4", 8'(i));
        chk("wrap_count12", {27'd0, count}, 32'd12);
        for (int i = 16; i < 20; i++) wr(8'(i));
        chk("wrap_full", {31'd0, full}, 32'd1);
        for (int i = 4; i < 20; i++) pop_chk("wrap_drain", 8'(i));
        chk("wrap_empty", {31'd0, empty}, 32'd1);
        chk("wrap_count", {27'd0, count}, 32'd0);

        // Overflow: three drops, contents untouched
        for (int i = 0; i < 16; i++) wr(8'(i));
        for (int i = 0; i < 3; i++) wr(8'hEE);
        chk("ovf_flag",  {31'd0, overflow}, 32'd1);
        chk("ovf_drops", {24'd0, drop_cnt}, 32'd3);
        chk("ovf_count", {27'd0, count}, 32'd16);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("clr_flag",  {31'd0, overflow}, 32'd0);
        chk("clr_drops", {24'd0, drop_cnt}, 32'd0);

        // Write and pop together at full
        chk("wp_head", {24'd0, rd_data}, 32'h00);
        eoc_flag  = 1'b1;
        buffer_RX = 8'h77;
        rd_en     = 1'b1;
        tick();
        eoc_flag = 1'b0;
        rd_en    = 1'b0;
        chk("wp_count", {27'd0, count}, 32'd16);
        chk("wp_ovf",   {31'd0, overflow}, 32'd0);
        tick();
        for (int i = 1; i < 16; i++) pop_chk("ovf_drain", 8'(i));
        pop_chk("ovf_drain_last", 8'h77);
        chk("ovf_drain_empty", {31'd0, empty}, 32'd1);

        // Write with rd_en at empty: write wins, pop ignored
        eoc_flag  = 1'b1;
        buffer_RX = 8'h42;
        rd_en     = 1'b1;
        tick();
        eoc_flag = 1'b0;
        rd_en    = 1'b0;
        chk("we_empty_count", {27'd0, count}, 32'd1);
        chk("we_empty_data",  {24'd0, rd_data}, 32'h42);
        tick();
        pop_chk("we_empty_pop", 8'h42);

        // Saturation
        for (int i = 0; i < 16; i++) wr(8'(i + 8'h80));
        for (int i = 0; i < 300; i++) wr(8'hFE);
        chk("sat_drops", {24'd0, drop_cnt}, 32'd255);
        chk("sat_flag",  {31'd0, overflow}, 32'd1);

        // Drop and clear in the same cycle: set wins
        eoc_flag     = 1'b1;
        buffer_RX    = 8'hFD;
        clr_overflow = 1'b1;
        tick();
        eoc_flag     = 1'b0;
        clr_overflow = 1'b0;
        chk("prio_flag",  {31'd0, overflow}, 32'd1);
        chk("prio_drops", {24'd0, drop_cnt}, 32'd1);
        tick();
        for (int i = 0; i < 16; i++) pop_chk("sat_drain", 8'(i + 8'h80));
        chk("sat_drain_empty", {31'd0, empty}, 32'd1);

        // Reset mid-stream, overflow still set from above
        for (int i = 0; i < 7; i++) wr(8'(i + 8'h20));
        chk("mid_count7", {27'd0, count}, 32'd7);
        rst = 1'b0;
        #1;
        chk("mid_rst_count", {27'd0, count}, 32'd0);
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_ovf",   {31'd0, overflow}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        wr(8'h5A);
        chk("post_rst_count", {27'd0, count}, 32'd1);
        chk("post_rst_data",  {24'd0, rd_data}, 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
